// File: rtl/alu_op_issue.sv
// ---------------------------------------------------------------------------
// alu_op_issue
//
// Producer side of the ALU Operation interface. Decoded instruction fields
// from the decode stage (ALUOp class, funct3, funct7[5]) are translated into
// a 4-bit ALU operation code and handed to the execute stage through a
// registered valid/ready stage backed by a 2-entry skid buffer (main output
// register plus one skid register).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   decode-side handshake; in_ready is registered
//   ALUOp               instruction class (000 mem, 001 branch, 010 R,
//                       011 I-type ALU, 100 LUI)
//   Funct3, Funct7b5    instr[14:12] and instr[30]
//   flush               synchronous drop of all buffered entries
//   out_valid/out_ready execute-side handshake
//   Operation           ALU operation code of the head entry
//   illegal             head entry came from an unsupported encoding
//
// Optional feature (macro ALU_OP_ISSUE_PERF_EN):
//   adds issue_count / illegal_count, 16-bit saturating counters of output
//   transfers and of illegal output transfers. Cleared by reset only.
// ---------------------------------------------------------------------------
module alu_op_issue #(
  parameter int OPCODE_LENGTH = 4,
  parameter int ALUOP_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALUOP_WIDTH-1:0]   ALUOp,
  input  logic [2:0]               Funct3,
  input  logic                     Funct7b5,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
`ifdef ALU_OP_ISSUE_PERF_EN
  output logic [15:0]              issue_count,
  output logic [15:0]              illegal_count,
`endif
  output logic                     illegal
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = 'd0;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = 'd1;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = 'd2;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = 'd5;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = 'd6;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = 'd7;
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = 'd8;
  localparam logic [OPCODE_LENGTH-1:0] OP_NE  = 'd9;
  localparam logic [OPCODE_LENGTH-1:0] OP_GE  = 'd10;
  localparam logic [OPCODE_LENGTH-1:0] OP_LUI = 'd11;
  localparam logic [OPCODE_LENGTH-1:0] OP_LT  = 'd12;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = 'd14;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = 'd15;

  localparam logic [ALUOP_WIDTH-1:0] CLS_MEM = 'd0;
  localparam logic [ALUOP_WIDTH-1:0] CLS_BR  = 'd1;
  localparam logic [ALUOP_WIDTH-1:0] CLS_R   = 'd2;
  localparam logic [ALUOP_WIDTH-1:0] CLS_I   = 'd3;
  localparam logic [ALUOP_WIDTH-1:0] CLS_LUI = 'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic [OPCODE_LENGTH-1:0] main_op_q, main_op_d;
  logic                     main_ill_q, main_ill_d;
  logic [OPCODE_LENGTH-1:0] skid_op_q, skid_op_d;
  logic                     skid_ill_q, skid_ill_d;

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_ill;
  logic                     in_xfer;
  logic                     out_xfer;

  // Field decode. R-type and I-type share the funct3 table; only funct3=000
  // differs (I-type has no SUB, so b5 is an immediate bit there).
  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (ALUOp)
      CLS_MEM: dec_op = OP_ADD;
      CLS_LUI: dec_op = OP_LUI;
      CLS_BR: begin
        case (Funct3)
          3'b000:  dec_op = OP_EQ;
          3'b001:  dec_op = OP_NE;
          3'b100:  dec_op = OP_LT;
          3'b101:  dec_op = OP_GE;
          default: dec_ill = 1'b1;
        endcase
      end
      CLS_R, CLS_I: begin
        case (Funct3)
          3'b000:  dec_op = ((ALUOp == CLS_R) && Funct7b5) ? OP_SUB : OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b100:  dec_op = OP_XOR;
          3'b010:  dec_op = OP_LT;
          3'b001: begin
            if (Funct7b5) dec_ill = 1'b1;
            else          dec_op  = OP_SLL;
          end
          3'b101:  dec_op = Funct7b5 ? OP_SRA : OP_SRL;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_op = '0;
  end

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid && out_ready;

  // Buffer next-state. in_ready_q is 0 only in FULL, so an input transfer
  // never coincides with FULL. Flush overrides everything but lets the
  // current output handshake complete (the consumer already took it).
  always_comb begin
    state_d    = state_q;
    main_op_d  = main_op_q;
    main_ill_d = main_ill_q;
    skid_op_d  = skid_op_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_op_d  = dec_op;
            main_ill_d = dec_ill;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_op_d  = dec_op;
            main_ill_d = dec_ill;
          end else if (in_xfer) begin
            skid_op_d  = dec_op;
            skid_ill_d = dec_ill;
            state_d    = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_op_d  = skid_op_q;
            main_ill_d = skid_ill_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_op_q  <= '0;
      main_ill_q <= 1'b0;
      skid_op_q  <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_op_q  <= main_op_d;
      main_ill_q <= main_ill_d;
      skid_op_q  <= skid_op_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign Operation = main_op_q;
  assign illegal   = main_ill_q;

`ifdef ALU_OP_ISSUE_PERF_EN
  logic [15:0] issue_count_q, issue_count_d;
  logic [15:0] illegal_count_q, illegal_count_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    issue_count_d   = issue_count_q;
    illegal_count_d = illegal_count_q;
    if (out_xfer && (issue_count_q != 16'hFFFF))
      issue_count_d = issue_count_q + 16'd1;
    if (out_xfer && main_ill_q && (illegal_count_q != 16'hFFFF))
      illegal_count_d = illegal_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q   <= '0;
      illegal_count_q <= '0;
    end else begin
      issue_count_q   <= issue_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign issue_count   = issue_count_q;
  assign illegal_count = illegal_count_q;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed testbench for alu_op_issue: decode table, backpressure through the
// skid buffer, flush, asynchronous reset, and (when ALU_OP_ISSUE_PERF_EN is
// defined) the transfer counters.
module tb_alu_op_issue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] ALUOp;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Operation;
  logic       illegal;
`ifdef ALU_OP_ISSUE_PERF_EN
  logic [15:0] issue_count;
  logic [15:0] illegal_count;
`endif

  int numCompared   = 0;
  int numMismatched = 0;

  alu_op_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .Funct3    (Funct3),
    .Funct7b5  (Funct7b5),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Operation (Operation),
`ifdef ALU_OP_ISSUE_PERF_EN
    .issue_count   (issue_count),
    .illegal_count (illegal_count),
`endif
    .illegal   (illegal)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] f3, input logic b5);
    in_valid = 1'b1;
    ALUOp    = a;
    Funct3   = f3;
    Funct7b5 = b5;
  endtask

  // One entry through an empty buffer with out_ready=1: visible one cycle
  // after acceptance, consumed the cycle after that.
  task automatic applyStimulus(input logic [2:0] a, input logic [2:0] f3, input logic b5,
                               input logic [3:0] expOp, input logic expIll);
    string tag;
    tag = $sformatf("dec a=%b f3=%b b5=%b", a, f3, b5);
    out_ready = 1'b1;
    drive(a, f3, b5);
    tick();
    in_valid = 1'b0;
    checkOutput({tag, " valid"}, 16'(out_valid), 16'h1);
    checkOutput({tag, " op"}, 16'(Operation), 16'(expOp));
    checkOutput({tag, " ill"}, 16'(illegal), 16'(expIll));
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ALUOp     = 3'b000;
    Funct3    = 3'b000;
    Funct7b5  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #12;
    checkOutput("rst out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst op", 16'(Operation), 16'h0);
    checkOutput("rst ill", 16'(illegal), 16'h0);
    checkOutput("rst in_ready", 16'(in_ready), 16'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // First transaction: R-type SUB
    applyStimulus(3'b010, 3'b000, 1'b1, 4'h6, 1'b0);
    checkOutput("drain empty", 16'(out_valid), 16'h0);

    // Decode table
    applyStimulus(3'b000, 3'b011, 1'b1, 4'h2, 1'b0);
    applyStimulus(3'b000, 3'b111, 1'b0, 4'h2, 1'b0);
    applyStimulus(3'b100, 3'b010, 1'b1, 4'hB, 1'b0);
    applyStimulus(3'b001, 3'b000, 1'b0, 4'h8, 1'b0);
    applyStimulus(3'b001, 3'b001, 1'b0, 4'h9, 1'b0);
    applyStimulus(3'b001, 3'b100, 1'b0, 4'hC, 1'b0);
    applyStimulus(3'b001, 3'b101, 1'b0, 4'hA, 1'b0);
    applyStimulus(3'b001, 3'b010, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b001, 3'b110, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b010, 3'b000, 1'b0, 4'h2, 1'b0);
    applyStimulus(3'b010, 3'b111, 1'b0, 4'h0, 1'b0);
    applyStimulus(3'b010, 3'b110, 1'b0, 4'h1, 1'b0);
    applyStimulus(3'b010, 3'b100, 1'b0, 4'h5, 1'b0);
    applyStimulus(3'b010, 3'b010, 1'b0, 4'hC, 1'b0);
    applyStimulus(3'b010, 3'b001, 1'b0, 4'h7, 1'b0);
    applyStimulus(3'b010, 3'b001, 1'b1, 4'h0, 1'b1);
    applyStimulus(3'b010, 3'b101, 1'b0, 4'hF, 1'b0);
    applyStimulus(3'b010, 3'b101, 1'b1, 4'hE, 1'b0);
    applyStimulus(3'b010, 3'b011, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b011, 3'b000, 1'b1, 4'h2, 1'b0);
    applyStimulus(3'b011, 3'b000, 1'b0, 4'h2, 1'b0);
    applyStimulus(3'b011, 3'b111, 1'b0, 4'h0, 1'b0);
    applyStimulus(3'b011, 3'b110, 1'b0, 4'h1, 1'b0);
    applyStimulus(3'b011, 3'b100, 1'b0, 4'h5, 1'b0);
    applyStimulus(3'b011, 3'b010, 1'b0, 4'hC, 1'b0);
    applyStimulus(3'b011, 3'b001, 1'b0, 4'h7, 1'b0);
    applyStimulus(3'b011, 3'b001, 1'b1, 4'h0, 1'b1);
    applyStimulus(3'b011, 3'b101, 1'b0, 4'hF, 1'b0);
    applyStimulus(3'b011, 3'b101, 1'b1, 4'hE, 1'b0);
    applyStimulus(3'b011, 3'b011, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b101, 3'b000, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b110, 3'b000, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b111, 3'b000, 1'b0, 4'h0, 1'b1);

    // Backpressure: ADD, XOR fill the buffer, SLL held at the input
    out_ready = 1'b0;
    drive(3'b000, 3'b000, 1'b0);
    tick();
    checkOutput("bp one in_ready", 16'(in_ready), 16'h1);
    drive(3'b010, 3'b100, 1'b0);
    tick();
    drive(3'b010, 3'b001, 1'b0);
    checkOutput("bp full in_ready", 16'(in_ready), 16'h0);
    checkOutput("bp full op", 16'(Operation), 16'h2);
    tick();
    checkOutput("bp hold in_ready", 16'(in_ready), 16'h0);
    checkOutput("bp hold op", 16'(Operation), 16'h2);
    checkOutput("bp hold valid", 16'(out_valid), 16'h1);
    out_ready = 1'b1;
    tick();
    checkOutput("bp second op", 16'(Operation), 16'h5);
    checkOutput("bp reopen in_ready", 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp third op", 16'(Operation), 16'h7);
    checkOutput("bp third valid", 16'(out_valid), 16'h1);
    tick();
    checkOutput("bp drained", 16'(out_valid), 16'h0);

    // Flush while FULL, with an input offered in the flush cycle
    out_ready = 1'b0;
    drive(3'b010, 3'b111, 1'b0);
    tick();
    drive(3'b010, 3'b110, 1'b0);
    tick();
    checkOutput("fl full in_ready", 16'(in_ready), 16'h0);
    drive(3'b010, 3'b000, 1'b1);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl out_valid", 16'(out_valid), 16'h0);
    checkOutput("fl in_ready", 16'(in_ready), 16'h1);
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("fl nothing appears", 16'(out_valid), 16'h0);
    applyStimulus(3'b010, 3'b100, 1'b0, 4'h5, 1'b0);

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    drive(3'b100, 3'b000, 1'b0);
    tick();
    drive(3'b010, 3'b101, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("ar pre op", 16'(Operation), 16'hB);
    checkOutput("ar pre in_ready", 16'(in_ready), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar out_valid", 16'(out_valid), 16'h0);
    checkOutput("ar op", 16'(Operation), 16'h0);
    checkOutput("ar ill", 16'(illegal), 16'h0);
    checkOutput("ar in_ready", 16'(in_ready), 16'h1);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("ar stays empty", 16'(out_valid), 16'h0);

`ifdef ALU_OP_ISSUE_PERF_EN
    // Five transfers, two of them illegal
    applyStimulus(3'b000, 3'b000, 1'b0, 4'h2, 1'b0);
    applyStimulus(3'b101, 3'b000, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b010, 3'b111, 1'b0, 4'h0, 1'b0);
    applyStimulus(3'b001, 3'b011, 1'b0, 4'h0, 1'b1);
    applyStimulus(3'b100, 3'b000, 1'b0, 4'hB, 1'b0);
    checkOutput("perf issue", issue_count, 16'd5);
    checkOutput("perf illegal", illegal_count, 16'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Producer side of the ALU `Operation` interface.
- Takes decoded instruction fields (`ALUOp` class, `funct3`, `funct7[5]`) from the decode stage and translates them into the 4-bit ALU operation code.
- Delivers the code to the execute stage through a registered valid/ready pipeline stage with a 2-entry skid buffer.
- Supports flush and illegal-encoding flagging.

Parameters:
- `OPCODE_LENGTH`, 4, width of the emitted ALU operation code.
- `ALUOP_WIDTH`, 3, width of the instruction-class input.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  decode stage presents fields.
- `in_ready`  out  1  stage can accept; registered.
- `ALUOp`  in  `ALUOP_WIDTH`  class: 000 mem/addr, 001 branch, 010 R-type, 011 I-type ALU, 100 LUI.
- `Funct3`  in  3  instr[14:12].
- `Funct7b5`  in  1  instr[30].
- `flush`  in  1  drop all buffered entries.
- `out_valid`  out  1  `Operation` valid.
- `out_ready`  in  1  execute stage accepts.
- `Operation`  out  `OPCODE_LENGTH`  ALU code.
- `illegal`  out  1  current output entry was an unsupported encoding.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - `out_valid`=0, `Operation`=0000, `illegal`=0, `in_ready`=1.
  - Both buffer entries invalid.
  - Takes effect immediately, mid-transfer included.
- Code map:
  - AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, SLL 0111.
  - EQ 1000, NE 1001, GE 1010, LUI 1011, LT 1100, SRA 1110, SRL 1111.
- Decode, combinational, applied before buffering:
  - 000 → ADD, regardless of `funct`.
  - 100 → LUI.
  - 001 (branch), by `funct3`: 000 EQ, 001 NE, 100 LT, 101 GE. Others illegal.
  - 010 (R-type), by `funct3`:
    - 000: SUB if `b5` else ADD.
    - 111 AND, 110 OR, 100 XOR, 010 LT.
    - 001: SLL, legal only if `b5`=0.
    - 101: SRA if `b5` else SRL.
    - 011 illegal.
  - 011 (I-type):
    - Same as R-type except 000 is always ADD.
    - 001 requires `b5`=0.
  - `ALUOp` values 101–111 are illegal.
  - Illegal entries: `Operation`=0000, `illegal`=1.
- Handshake:
  - Transfer on a side when valid&&ready are both 1 at the rising edge.
  - `Operation`/`illegal` remain stable while `out_valid`=1 and `out_ready`=0.
- Buffer: main output register plus one skid register.
  - States: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
  - `in_ready` = 1 in EMPTY/ONE, 0 in FULL; registered, not a combinational function of `out_ready`.
  - EMPTY + in xfer → ONE; `out_valid`=1 next cycle. Latency 1 cycle.
  - ONE + in xfer + out xfer → ONE, main loaded with new entry.
  - ONE + in xfer, no out xfer → FULL; entry goes to skid.
  - ONE + out xfer only → EMPTY.
  - FULL + out xfer → ONE; skid moves to main. `in_ready` returns to 1 the following cycle.
  - FULL: no input accepted.
- Flush:
  - Synchronous; highest priority.
  - Next state EMPTY, `out_valid`=0, `in_ready`=1.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle still completes.
- Ordering: strict FIFO; no entry duplicated or lost without flush.

Optional Feature:
- Macro `ALU_OP_ISSUE_PERF_EN`.
- Defined:
  - Adds output ports `issue_count` (16) and `illegal_count` (16).
  - `issue_count` increments per output transfer; `illegal_count` increments per output transfer with `illegal`=1.
  - Both saturate at 16'hFFFF.
  - Both clear on reset only; flush does not clear them.
- Undefined: ports and counters are absent; all other behaviour identical.

Test Plan:
- Reset release, then `in_valid`=1, `ALUOp`=010, `funct3`=000, `b5`=1, `out_ready`=1 → next cycle `out_valid`=1, `Operation`=0110, `illegal`=0.
- Sweep all legal `ALUOp`/`funct3`/`b5` combinations with `out_ready`=1 → each matches the code map. 011/001/`b5`=1 → 0000, `illegal`=1. 001/010 → `illegal`=1.
- `out_ready`=0, send ADD then XOR:
  - `in_ready` drops to 0 after the second accept; third input held.
  - `Operation` stays 0010.
  - Raise `out_ready` → outputs 0010, then 0101, then the third entry, in order.
- FULL, then `flush`=1 for one cycle with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; flushed input never appears.
- Assert `rst_n`=0 asynchronously mid-cycle while FULL → `out_valid`, `Operation`, `illegal` go to 0 and `in_ready` to 1 before the next clock edge.
- With `ALU_OP_ISSUE_PERF_EN`: 5 transfers including 2 illegal → `issue_count`=5, `illegal_count`=2. Preload near 16'hFFFF → counters saturate.
